// File: rtl/rqb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rqb_pkg
//  Description : Shared definitions for the request queue bank. It holds the
//                default configuration, the source-tag width helper and the
//                entry/output record types for the default build.
//                Optional checks in the bank are enabled by the macro
//                RQB_GRANT_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package rqb_pkg;

    localparam int C_N_DEF     = 4;
    localparam int C_DW_DEF    = 8;
    localparam int C_DEPTH_DEF = 4;

    // Width of a source index. A single-source bank still needs a one-bit
    // tag, so this never returns zero.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SRC_W = src_w(C_N_DEF);

    typedef logic [C_DW_DEF-1:0] rqb_entry_t;

    typedef struct packed {
        logic             valid;
        logic [SRC_W-1:0] src;
        rqb_entry_t       data;
    } rqb_out_t;

endpackage
`default_nettype wire

// File: rtl/rqb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rqb_sync_fifo
//  Description : Small synchronous FIFO used once per requester.
//                The caller must gate push with !full. A pop of an empty FIFO
//                is ignored. The head entry is always visible on head_data.
//                With RQB_GRANT_CHECK_EN defined, simulation checks flag a
//                push into a full FIFO and a count above DEPTH.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                push/push_data - write strobe and payload
//                pop            - remove the head entry
//                head_data      - oldest entry
//                full/empty     - status decoded from the registered count
//                count          - number of stored entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module rqb_sync_fifo
    import rqb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               C_PW   = $clog2(DEPTH);
    localparam logic [C_PW:0]    C_FULL = (C_PW + 1)'(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [C_PW-1:0] r_wptr;
    logic [C_PW-1:0] r_rptr;
    logic [C_PW:0]   r_count;
    logic            w_wr_en;
    logic            w_rd_en;

    // The write enable is trusted as-is so that the optional check can see
    // an illegal push rather than having it silently masked here.
    assign w_wr_en = push;
    assign w_rd_en = pop & (r_count != '0);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    assign head_data = r_mem[r_rptr];
    assign full      = (r_count == C_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;

`ifdef RQB_GRANT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_wr_en && full) begin
                $error("rqb_sync_fifo: push while full");
            end
            if (r_count > C_FULL) begin
                $error("rqb_sync_fifo: count %0d exceeds depth %0d", r_count, DEPTH);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/req_queue_bank.sv
`default_nettype none
// ============================================================================
//  Module      : req_queue_bank
//  Description : Per-requester buffering around a round-robin arbiter.
//                One FIFO per source feeds req; the arbiter's registered
//                one-hot grant pops the chosen FIFO into a single registered
//                output channel tagged with the source index.
//                With RQB_GRANT_CHECK_EN defined, a simulation check reports
//                grants that are neither zero nor one-hot; ports and
//                behaviour are unchanged either way.
//  Ports       : clk, reset              - clock, synchronous active-high reset
//                in_valid/in_data/in_ready - per-source push handshake
//                req                     - FIFO i non-empty, to the arbiter
//                grant                   - registered grant from the arbiter
//                out_valid/out_data/out_src/out_ready - output channel
//  Revision    : 1.0 - initial release
// ============================================================================
module req_queue_bank
    import rqb_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          in_valid,
    input  logic [N*DW-1:0]       in_data,
    output logic [N-1:0]          in_ready,
    output logic [N-1:0]          req,
    input  logic [N-1:0]          grant,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic [src_w(N)-1:0]   out_src,
    input  logic                  out_ready
);

    localparam int C_SRC_W = src_w(N);
    localparam int C_CW    = $clog2(DEPTH);

    typedef struct packed {
        logic               valid;
        logic [C_SRC_W-1:0] src;
        logic [DW-1:0]      data;
    } out_t;

    logic [N-1:0]       w_full;
    logic [N-1:0]       w_empty;
    logic [N-1:0]       w_push;
    logic [N-1:0]       w_pop;
    logic [DW-1:0]      w_head  [N];
    logic [C_CW:0]      w_count [N];
    logic [N-1:0]       w_svc;
    logic [C_SRC_W-1:0] w_sel;
    logic               w_out_free;
    logic               w_load;
    out_t               r_out;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fifo
            // Ready comes from the registered count only, so a pop in the
            // same cycle never opens a slot for a push into a full FIFO.
            assign w_push[gi]   = in_valid[gi] & ~w_full[gi];
            assign in_ready[gi] = ~w_full[gi];
            assign req[gi]      = (w_count[gi] != '0);
            assign w_pop[gi]    = w_load & (w_sel == C_SRC_W'(gi));

            rqb_sync_fifo #(
                .DW    (DW),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (w_push[gi]),
                .push_data (in_data[gi*DW +: DW]),
                .pop       (w_pop[gi]),
                .head_data (w_head[gi]),
                .full      (w_full[gi]),
                .empty     (w_empty[gi]),
                .count     (w_count[gi])
            );
        end
    endgenerate

    // Grants to empty FIFOs are dropped before picking a winner; this covers
    // the stale grant that arrives one cycle after a FIFO's last pop. Among
    // what remains the lowest index wins.
    assign w_svc      = grant & ~w_empty;
    assign w_out_free = ~r_out.valid | out_ready;
    assign w_load     = w_out_free & (|w_svc);

    always_comb begin
        w_sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_svc[i]) begin
                w_sel = C_SRC_W'(i);
            end
        end
    end

    // Data and source are held when the channel drains so the last
    // transaction stays observable; only valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_load) begin
            r_out.valid <= 1'b1;
            r_out.src   <= w_sel;
            r_out.data  <= w_head[w_sel];
        end else if (out_ready) begin
            r_out.valid <= 1'b0;
        end
    end

    assign out_valid = r_out.valid;
    assign out_data  = r_out.data;
    assign out_src   = r_out.src;

`ifdef RQB_GRANT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset && ((grant & (grant - 1'b1)) != '0)) begin
            $error("req_queue_bank: grant %b is not zero or one-hot", grant);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_queue_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_queue_bank
//  Description : Self-checking bench for req_queue_bank. A queue-based model
//                predicts every output each cycle; a vector table, directed
//                arbiter sequences and a randomized phase drive the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_queue_bank;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_ready;

    always #5 clk = ~clk;

    req_queue_bank #(
        .N     (N),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per source plus the output slot.
    logic [DW-1:0] mq [N][$];
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic [1:0]    m_os;

    // Round-robin arbiter stand-in: grant for the next cycle from this
    // cycle's req.
    bit            arb_en;
    logic [N-1:0]  arb_q;
    int            arb_last;

    logic [DW-1:0] cap_d [$];
    int            cap_s [$];
    int            cap_cyc [$];
    int            cyc = 0;

    typedef struct {
        logic            rst;
        logic [N-1:0]    iv;
        logic [N*DW-1:0] id;
        logic [N-1:0]    gnt;
        logic            ordy;
        logic            ov;
        logic [DW-1:0]   od;
        logic [1:0]      os;
        logic [N-1:0]    rq;
        logic [N-1:0]    ir;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int sz [N];
        int k;
        bit free;
        if (reset) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_ov = 1'b0;
            m_od = '0;
            m_os = '0;
        end else begin
            for (int i = 0; i < N; i++) sz[i] = mq[i].size();
            free = !m_ov || out_ready;
            k = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (grant[i] && sz[i] > 0) k = i;
            end
            if (free && k >= 0) begin
                m_od = mq[k].pop_front();
                m_os = 2'(k);
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && sz[i] < DEPTH) mq[i].push_back(in_data[i*DW +: DW]);
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] e_req;
        logic [N-1:0] e_rdy;
        if (arb_en) grant = arb_q;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            e_req[i] = (mq[i].size() != 0);
            e_rdy[i] = (mq[i].size() < DEPTH);
        end
        chk("model_out_valid", 32'(out_valid), 32'(m_ov));
        chk("model_out_data", 32'(out_data), 32'(m_od));
        chk("model_out_src", 32'(out_src), 32'(m_os));
        chk("model_req", 32'(req), 32'(e_req));
        chk("model_in_ready", 32'(in_ready), 32'(e_rdy));
        if (out_valid === 1'b1) begin
            cap_d.push_back(out_data);
            cap_s.push_back(int'(out_src));
            cap_cyc.push_back(cyc);
        end
        if (arb_en) begin
            arb_q = '0;
            for (int o = 1; o <= N; o++) begin
                int idx;
                idx = (arb_last + o) % N;
                if (req[idx] === 1'b1) begin
                    arb_q[idx] = 1'b1;
                    arb_last   = idx;
                    break;
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = '0;
        grant    = '0;
        for (int i = 0; i < n; i++) cycle();
        reset = 1'b0;
    endtask

    task automatic clear_caps();
        cap_d.delete();
        cap_s.delete();
        cap_cyc.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        grant     = '0;
        out_ready = 1'b1;
        arb_en    = 1'b0;
        arb_q     = '0;
        arb_last  = 0;
        m_ov      = 1'b0;
        m_od      = '0;
        m_os      = '0;

        //           rst   iv     id             gnt    ordy  | ov    od     os    rq     ir
        tbl[0]  = '{1'b1, 4'hF, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 4'h0, 4'hF};
        tbl[1]  = '{1'b1, 4'hF, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 4'h0, 4'hF};
        tbl[2]  = '{1'b0, 4'h1, 32'h0000_0050, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 4'h1, 4'hF};
        tbl[3]  = '{1'b0, 4'h1, 32'h0000_0051, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 4'h1, 4'hF};
        tbl[4]  = '{1'b0, 4'h1, 32'h0000_0052, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 4'h1, 4'hF};
        tbl[5]  = '{1'b0, 4'h1, 32'h0000_0053, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 4'h1, 4'hE};
        tbl[6]  = '{1'b0, 4'h1, 32'h0000_0054, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0, 4'h1, 4'hE};
        tbl[7]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b0, 1'b1, 8'h50, 2'd0, 4'h1, 4'hF};
        tbl[8]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b0, 1'b1, 8'h50, 2'd0, 4'h1, 4'hF};
        tbl[9]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b0, 1'b1, 8'h50, 2'd0, 4'h1, 4'hF};
        tbl[10] = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b0, 1'b1, 8'h50, 2'd0, 4'h1, 4'hF};
        tbl[11] = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b1, 1'b1, 8'h51, 2'd0, 4'h1, 4'hF};
        tbl[12] = '{1'b0, 4'h0, 32'h0000_0000, 4'h4, 1'b1, 1'b0, 8'h51, 2'd0, 4'h1, 4'hF};
        tbl[13] = '{1'b0, 4'h6, 32'h0062_6100, 4'h0, 1'b0, 1'b0, 8'h51, 2'd0, 4'h7, 4'hF};
        tbl[14] = '{1'b0, 4'h0, 32'h0000_0000, 4'h6, 1'b1, 1'b1, 8'h61, 2'd1, 4'h5, 4'hF};
        tbl[15] = '{1'b0, 4'h0, 32'h0000_0000, 4'h4, 1'b1, 1'b1, 8'h62, 2'd2, 4'h1, 4'hF};
        tbl[16] = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b1, 1'b1, 8'h52, 2'd0, 4'h1, 4'hF};
        tbl[17] = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b1, 1'b1, 8'h53, 2'd0, 4'h0, 4'hF};
        tbl[18] = '{1'b0, 4'h0, 32'h0000_0000, 4'h1, 1'b1, 1'b0, 8'h53, 2'd0, 4'h0, 4'hF};
        tbl[19] = '{1'b0, 4'h2, 32'h0000_7700, 4'h0, 1'b1, 1'b0, 8'h53, 2'd0, 4'h2, 4'hF};
        tbl[20] = '{1'b1, 4'h0, 32'h0000_0000, 4'h2, 1'b1, 1'b0, 8'h00, 2'd0, 4'h0, 4'hF};
        tbl[21] = '{1'b0, 4'h0, 32'h0000_0000, 4'h2, 1'b1, 1'b0, 8'h00, 2'd0, 4'h0, 4'hF};

        // Table: reset, fill/overflow, backpressure, stale and multi-bit
        // grants, mid-operation reset.
        for (int v = 0; v < 22; v++) begin
            reset     = tbl[v].rst;
            in_valid  = tbl[v].iv;
            in_data   = tbl[v].id;
            grant     = tbl[v].gnt;
            out_ready = tbl[v].ordy;
            cycle();
            chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(tbl[v].ov));
            chk($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(tbl[v].od));
            chk($sformatf("vec%0d_out_src", v), 32'(out_src), 32'(tbl[v].os));
            chk($sformatf("vec%0d_req", v), 32'(req), 32'(tbl[v].rq));
            chk($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(tbl[v].ir));
        end

        // Single source through the arbiter: A1, A2, A3 from source 2.
        out_ready = 1'b1;
        do_reset(2);
        arb_en = 1'b1; arb_q = '0; arb_last = 0;
        clear_caps();
        in_valid = 4'b0100;
        in_data  = 32'h00A1_0000; cycle();
        in_data  = 32'h00A2_0000; cycle();
        in_data  = 32'h00A3_0000; cycle();
        in_valid = '0;
        for (int i = 0; i < 8; i++) cycle();
        chk("single_count", 32'(cap_d.size()), 32'd3);
        for (int i = 0; i < 3 && i < cap_d.size(); i++) begin
            chk($sformatf("single_data%0d", i), 32'(cap_d[i]), 32'(8'hA1 + i));
            chk($sformatf("single_src%0d", i), 32'(cap_s[i]), 32'd2);
        end
        chk("single_req_drop", 32'(req), 32'd0);

        // All sources loaded, round robin from last_grant 0: 1,2,3,0.
        arb_en = 1'b0;
        do_reset(1);
        in_valid = 4'hF;
        in_data  = 32'h1312_1110;
        cycle();
        in_valid = '0;
        arb_en = 1'b1; arb_q = '0; arb_last = 0;
        clear_caps();
        for (int i = 0; i < 8; i++) cycle();
        chk("rr_count", 32'(cap_s.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap_s.size(); i++) begin
            chk($sformatf("rr_src%0d", i), 32'(cap_s[i]), 32'((i + 1) % 4));
            chk($sformatf("rr_data%0d", i), 32'(cap_d[i]), 32'(8'h10 + (i + 1) % 4));
            if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd1);
        end

        // Randomized: arbiter-driven, then free-form grants incl. multi-hot.
        do_reset(1);
        for (int c = 0; c < 700; c++) begin
            arb_en    = (c < 350);
            reset     = ($urandom_range(0, 99) == 0);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!arb_en) begin
                case ($urandom_range(0, 3))
                    0:       grant = '0;
                    1:       grant = 4'($urandom);
                    default: grant = 4'(1 << $urandom_range(0, 3));
                endcase
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
